// File: rtl/kws_pkg.sv
// Shared types and helpers for the keyword-spotting classifier back end.
// Holds the class enum, fixed-width integer typedefs, the FSM state encoding
// and the saturating round-half-up requantizer used on every logit.
package kws_pkg;

    localparam int KWS_NUM_CLASSES = 4;

    typedef enum logic [1:0] {
        CLS_SILENCE = 2'd0,
        CLS_UNKNOWN = 2'd1,
        CLS_YES     = 2'd2,
        CLS_NO      = 2'd3
    } kws_class_e;

    typedef logic signed [7:0]  int8_t;
    typedef logic signed [31:0] int32_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIAS_RD,
        ST_BIAS_CAP,
        ST_MAC,
        ST_DRAIN,
        ST_REQUANT,
        ST_FINISH
    } fc_state_e;

    // Round half up, arithmetic right shift, clamp to int8.
    // Done in 64 bits so the rounding add can never wrap for a 32-bit acc.
    function automatic int8_t requant(input logic signed [63:0] acc, input int shift);
        logic signed [63:0] rnd;
        logic signed [63:0] res;
        rnd = acc + (64'sd1 <<< (shift - 1));
        res = rnd >>> shift;
        if (res > 64'sd127) begin
            return 8'sh7f;
        end else if (res < -64'sd128) begin
            return 8'sh80;
        end
        return $signed(res[7:0]);
    endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// Zero-point subtract, 9x8 signed multiply and wrapping accumulator.
// Latency: product of the current x/w is folded into acc at the next edge.
// No backpressure: load has priority over acc_en, otherwise acc holds.
// Ports: clk/rst, load + load_val (bias preload), acc_en, x/w int8 operands,
//        acc accumulator output.
module fc_mac_unit
    import kws_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int IN_ZP = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic signed [ACC_W-1:0] load_val,
    input  logic                    acc_en,
    input  int8_t                   x,
    input  int8_t                   w,
    output logic signed [ACC_W-1:0] acc
);

    localparam logic signed [8:0] ZP9 = 9'(IN_ZP);

    logic signed [8:0]  diff;
    logic signed [16:0] diff17;
    logic signed [16:0] w17;
    logic signed [16:0] prod;

    // Worst-case |diff| = 255, |w| = 128, so the product always fits 17 bits.
    assign diff   = 9'(x) - ZP9;
    assign diff17 = 17'(diff);
    assign w17    = 17'(w);
    assign prod   = diff17 * w17;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (load) begin
            acc <= load_val;
        end else if (acc_en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/fc_classifier.sv
// Fully-connected classifier: per-class int8 dot product + bias, requantized logits, argmax.
// Latency: done pulses NUM_CLASSES*(IN_LEN+4)+1 cycles after start is accepted.
// No backpressure: logits are one-cycle strobes; start is ignored while busy.
// Ports: start/busy/done control; in_ram, w_rom, b_rom one-cycle-latency read ports;
//        logit_valid/idx/data stream; class_id/class_score argmax result.
module fc_classifier
    import kws_pkg::*;
#(
    parameter int IN_LEN      = 4000,
    parameter int NUM_CLASSES = KWS_NUM_CLASSES,
    parameter int ADDR_W      = 13,
    parameter int W_ADDR_W    = 14,
    parameter int ACC_W       = 32,
    parameter int IN_ZP       = 0,
    parameter int OUT_SHIFT   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic [ADDR_W-1:0]              in_ram_addr,
    input  logic signed [7:0]              in_ram_rdata,
    output logic [W_ADDR_W-1:0]            w_rom_addr,
    input  logic signed [7:0]              w_rom_rdata,
    output logic [$clog2(NUM_CLASSES)-1:0] b_rom_addr,
    input  logic signed [31:0]             b_rom_rdata,
    output logic                           logit_valid,
    output logic [$clog2(NUM_CLASSES)-1:0] logit_idx,
    output logic signed [7:0]              logit_data,
    output logic [$clog2(NUM_CLASSES)-1:0] class_id,
    output logic signed [7:0]              class_score
);

    localparam int CLS_W = $clog2(NUM_CLASSES);

    fc_state_e               state;
    fc_state_e               state_nxt;

    logic [CLS_W-1:0]        c;
    logic [ADDR_W-1:0]       j;
    logic [W_ADDR_W-1:0]     wptr;
    logic [ADDR_W-1:0]       in_addr_hold;
    logic [W_ADDR_W-1:0]     w_addr_hold;
    logic [CLS_W-1:0]        b_addr_hold;

    int8_t                   max_score;
    logic [CLS_W-1:0]        max_id;

    logic signed [ACC_W-1:0] acc;
    int8_t                   r;
    logic                    last_j;
    logic                    last_c;
    logic                    mac_load;
    logic                    mac_acc;

    assign last_j = (j == ADDR_W'(IN_LEN - 1));
    assign last_c = (c == CLS_W'(NUM_CLASSES - 1));
    assign r      = requant(64'(acc), OUT_SHIFT);

    fc_mac_unit #(
        .ACC_W (ACC_W),
        .IN_ZP (IN_ZP)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .load     (mac_load),
        .load_val (ACC_W'(b_rom_rdata)),
        .acc_en   (mac_acc),
        .x        (in_ram_rdata),
        .w        (w_rom_rdata),
        .acc      (acc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start) state_nxt = ST_BIAS_RD;
            ST_BIAS_RD:  state_nxt = ST_BIAS_CAP;
            ST_BIAS_CAP: state_nxt = ST_MAC;
            ST_MAC:      if (last_j) state_nxt = ST_DRAIN;
            ST_DRAIN:    state_nxt = ST_REQUANT;
            ST_REQUANT:  state_nxt = last_c ? ST_FINISH : ST_BIAS_RD;
            ST_FINISH:   state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Output / control decode. Addresses show the live counter only while
    // they are being issued and otherwise replay the last issued value.
    always_comb begin
        mac_load    = 1'b0;
        mac_acc     = 1'b0;
        in_ram_addr = in_addr_hold;
        w_rom_addr  = w_addr_hold;
        b_rom_addr  = b_addr_hold;
        case (state)
            ST_BIAS_RD:  b_rom_addr = c;
            ST_BIAS_CAP: mac_load = 1'b1;
            ST_MAC: begin
                in_ram_addr = j;
                w_rom_addr  = wptr;
                // Read data trails the address by one cycle, so the first
                // MAC cycle has nothing to accumulate yet.
                mac_acc     = (j != '0);
            end
            ST_DRAIN:    mac_acc = 1'b1;
            default: ;
        endcase
    end

    // Counters, argmax and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            c            <= '0;
            j            <= '0;
            wptr         <= '0;
            in_addr_hold <= '0;
            w_addr_hold  <= '0;
            b_addr_hold  <= '0;
            max_score    <= '0;
            max_id       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            logit_valid  <= 1'b0;
            logit_idx    <= '0;
            logit_data   <= '0;
            class_id     <= '0;
            class_score  <= '0;
        end else begin
            logit_valid <= 1'b0;
            done        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        c         <= '0;
                        wptr      <= '0;
                        max_score <= 8'sh80;
                        max_id    <= '0;
                        busy      <= 1'b1;
                    end
                end
                ST_BIAS_RD: begin
                    b_addr_hold <= c;
                end
                ST_BIAS_CAP: begin
                    j <= '0;
                end
                ST_MAC: begin
                    in_addr_hold <= j;
                    w_addr_hold  <= wptr;
                    j            <= j + ADDR_W'(1);
                    // wptr runs across class boundaries (class-major layout),
                    // so no c*IN_LEN base address is ever needed.
                    wptr         <= wptr + W_ADDR_W'(1);
                end
                ST_REQUANT: begin
                    logit_valid <= 1'b1;
                    logit_idx   <= c;
                    logit_data  <= r;
                    // Strict compare: on ties the earlier (lower) class wins.
                    if (r > max_score) begin
                        max_score <= r;
                        max_id    <= c;
                    end
                    if (!last_c) begin
                        c <= c + CLS_W'(1);
                    end
                end
                ST_FINISH: begin
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    class_id    <= max_id;
                    class_score <= max_score;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_classifier.sv
module tb_fc_classifier;

    localparam int IN_LEN   = 8;
    localparam int NC       = 4;
    localparam int ADDR_W   = 13;
    localparam int W_ADDR_W = 14;
    localparam int CLS_W    = 2;
    localparam int EXP_LAT  = NC * (IN_LEN + 4) + 1;
    localparam int TIMEOUT  = 400;

    typedef struct {
        int act_mode;   // 0: x=j, 1: all 0, 2: all 127, 3: preloaded
        int w_mode;     // 0: c+1, 1: all 0, 2: 127/-128/0/0, 3: preloaded
        int bias[4];
        int logit[4];
        int cls;
        int score;
    } vec_t;

    typedef struct {
        int idx;
        int val;
    } logit_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic                     busy;
    logic                     done;
    logic [ADDR_W-1:0]        in_ram_addr;
    logic signed [7:0]        in_ram_rdata;
    logic [W_ADDR_W-1:0]      w_rom_addr;
    logic signed [7:0]        w_rom_rdata;
    logic [CLS_W-1:0]         b_rom_addr;
    logic signed [31:0]       b_rom_rdata;
    logic                     logit_valid;
    logic [CLS_W-1:0]         logit_idx;
    logic signed [7:0]        logit_data;
    logic [CLS_W-1:0]         class_id;
    logic signed [7:0]        class_score;

    logic signed [7:0]        act_mem [8];
    logic signed [7:0]        w_mem   [32];
    logic signed [31:0]       b_mem   [4];

    int      checks   = 0;
    int      failures = 0;
    logit_t  sb_q[$];
    logit_t  sb_e;
    vec_t    tbl[4];

    always #5 clk = ~clk;

    fc_classifier #(
        .IN_LEN      (IN_LEN),
        .NUM_CLASSES (NC),
        .ADDR_W      (ADDR_W),
        .W_ADDR_W    (W_ADDR_W),
        .ACC_W       (32),
        .IN_ZP       (0),
        .OUT_SHIFT   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .in_ram_addr  (in_ram_addr),
        .in_ram_rdata (in_ram_rdata),
        .w_rom_addr   (w_rom_addr),
        .w_rom_rdata  (w_rom_rdata),
        .b_rom_addr   (b_rom_addr),
        .b_rom_rdata  (b_rom_rdata),
        .logit_valid  (logit_valid),
        .logit_idx    (logit_idx),
        .logit_data   (logit_data),
        .class_id     (class_id),
        .class_score  (class_score)
    );

    // One-cycle registered-read memories
    always @(posedge clk) begin
        in_ram_rdata <= act_mem[in_ram_addr[2:0]];
        w_rom_rdata  <= w_mem[w_rom_addr[4:0]];
        b_rom_rdata  <= b_mem[b_rom_addr];
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Scoreboard consumer: every logit strobe must match the next expected entry
    always @(negedge clk) begin
        if (!rst && logit_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_logit: got idx=%0d data=%0d expected none",
                         logit_idx, logit_data);
            end else begin
                sb_e = sb_q.pop_front();
                chk("logit_idx", int'(logit_idx), sb_e.idx);
                chk("logit_data", int'(logit_data), sb_e.val);
            end
        end
    end

    function automatic int model_rq(input int acc);
        int t;
        int q;
        t = acc + 2;
        q = t / 4;
        if ((t % 4) != 0 && t < 0) q = q - 1;   // floor toward -inf
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    task automatic load_vec(input vec_t v);
        for (int jj = 0; jj < IN_LEN; jj++) begin
            case (v.act_mode)
                0: act_mem[jj] = 8'(jj);
                1: act_mem[jj] = 8'sd0;
                2: act_mem[jj] = 8'sd127;
                default: ;
            endcase
        end
        for (int cc = 0; cc < NC; cc++) begin
            if (v.act_mode != 3) b_mem[cc] = v.bias[cc];
            for (int jj = 0; jj < IN_LEN; jj++) begin
                case (v.w_mode)
                    0: w_mem[cc*IN_LEN+jj] = 8'(cc + 1);
                    1: w_mem[cc*IN_LEN+jj] = 8'sd0;
                    2: w_mem[cc*IN_LEN+jj] = (cc == 0) ? 8'sh7f : ((cc == 1) ? 8'sh80 : 8'sh00);
                    default: ;
                endcase
            end
        end
    endtask

    task automatic push_vec(input vec_t v);
        for (int cc = 0; cc < NC; cc++) sb_q.push_back('{cc, v.logit[cc]});
    endtask

    task automatic run_and_check(input string tag, input vec_t v, input int pulse_at);
        int lat;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk($sformatf("%s_busy_after_start", tag), int'(busy), 1);
        lat = 0;
        while (!done && lat < TIMEOUT) begin
            start = (lat == pulse_at);
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        chk($sformatf("%s_latency", tag), lat, EXP_LAT);
        chk($sformatf("%s_class_id", tag), int'(class_id), v.cls);
        chk($sformatf("%s_class_score", tag), int'(class_score), v.score);
        chk($sformatf("%s_busy_at_done", tag), int'(busy), 0);
        chk($sformatf("%s_logits_left", tag), sb_q.size(), 0);
        @(posedge clk);
        #1;
        chk($sformatf("%s_done_one_cycle", tag), int'(done), 0);
        chk($sformatf("%s_class_id_held", tag), int'(class_id), v.cls);
    endtask

    initial begin
        vec_t rv;
        int   acc;
        int   lat;
        int   dcnt;
        int   bcnt;

        rst   = 1'b1;
        start = 1'b0;

        tbl[0] = '{0, 0, '{0, 0, 0, 0},      '{7, 14, 21, 28},     3, 28};
        tbl[1] = '{1, 0, '{10, -5, 300, -6}, '{3, -1, 75, -1},     2, 75};
        tbl[2] = '{2, 2, '{0, 0, 0, 0},      '{127, -128, 0, 0},   0, 127};
        tbl[3] = '{0, 1, '{40, 40, 40, 40},  '{10, 10, 10, 10},    0, 10};

        load_vec(tbl[0]);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_logit_valid", int'(logit_valid), 0);
        chk("rst_logit_data", int'(logit_data), 0);
        chk("rst_class_id", int'(class_id), 0);
        chk("rst_class_score", int'(class_score), 0);
        chk("rst_in_ram_addr", int'(in_ram_addr), 0);
        chk("rst_w_rom_addr", int'(w_rom_addr), 0);
        rst = 1'b0;

        // Table-driven scenarios
        for (int i = 0; i < 4; i++) begin
            load_vec(tbl[i]);
            push_vec(tbl[i]);
            run_and_check($sformatf("tbl%0d", i), tbl[i], -1);
        end

        // Random small-magnitude run checked against an integer model
        for (int jj = 0; jj < IN_LEN; jj++) act_mem[jj] = 8'($urandom_range(0, 15)) - 8'sd8;
        for (int k = 0; k < NC * IN_LEN; k++) w_mem[k] = 8'($urandom_range(0, 15)) - 8'sd8;
        for (int cc = 0; cc < NC; cc++) b_mem[cc] = int'($urandom_range(0, 400)) - 200;
        rv.act_mode = 3;
        rv.w_mode   = 3;
        for (int cc = 0; cc < NC; cc++) begin
            acc = int'(b_mem[cc]);
            for (int jj = 0; jj < IN_LEN; jj++)
                acc = acc + int'(act_mem[jj]) * int'(w_mem[cc*IN_LEN+jj]);
            rv.bias[cc]  = int'(b_mem[cc]);
            rv.logit[cc] = model_rq(acc);
        end
        rv.cls   = 0;
        rv.score = rv.logit[0];
        for (int cc = 1; cc < NC; cc++) begin
            if (rv.logit[cc] > rv.score) begin
                rv.score = rv.logit[cc];
                rv.cls   = cc;
            end
        end
        push_vec(rv);
        run_and_check("rand", rv, -1);

        // Reset in the MAC phase of class 2: only logits 0 and 1 may appear
        load_vec(tbl[0]);
        sb_q.push_back('{0, 7});
        sb_q.push_back('{1, 14});
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (28) @(posedge clk);
        #1;
        chk("abort_busy_before_rst", int'(busy), 1);
        chk("abort_logits_before_rst", sb_q.size(), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_logit_valid", int'(logit_valid), 0);
        chk("abort_class_id", int'(class_id), 0);
        chk("abort_class_score", int'(class_score), 0);
        chk("abort_in_ram_addr", int'(in_ram_addr), 0);
        chk("abort_w_rom_addr", int'(w_rom_addr), 0);
        chk("abort_b_rom_addr", int'(b_rom_addr), 0);
        rst = 1'b0;
        dcnt = 0;
        bcnt = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
            if (busy) bcnt++;
        end
        chk("abort_no_done", dcnt, 0);
        chk("abort_stays_idle", bcnt, 0);
        push_vec(tbl[0]);
        run_and_check("after_abort", tbl[0], -1);

        // start pulsed mid-run is ignored
        push_vec(tbl[0]);
        run_and_check("start_in_busy", tbl[0], 10);

        // start held through done: back-to-back runs
        push_vec(tbl[0]);
        push_vec(tbl[0]);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        while (!done && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("hold_latency1", lat, EXP_LAT);
        chk("hold_class_id1", int'(class_id), 3);
        @(posedge clk);
        #1;
        chk("hold_busy_after_done", int'(busy), 1);
        chk("hold_done_dropped", int'(done), 0);
        start = 1'b0;
        lat = 0;
        while (!done && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("hold_latency2", lat, EXP_LAT);
        chk("hold_class_id2", int'(class_id), 3);
        chk("hold_class_score2", int'(class_score), 28);
        chk("hold_logits_left", sb_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
